vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences the 100 MHz system clock into 640x480@60 VGA scan timing.
//  Derives a one-cycle pixel-enable strobe (pix_tick, 25 MHz rate) in the clk domain; no derived clocks.
//  Runs horizontal/vertical scan counters on that strobe and decodes hsync, vsync, video_on and pixel coordinates.
//  Sits between the system clock and the game's pixel renderer / VGA pins.
// PARAMETERS
//  DIV       4    clk cycles per pixel; DIV>=1, DIV=1 -> pix_tick every cycle
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//  clk          in   1   master clock, 100 MHz
//  rst          in   1   reset, synchronous, active-low
//  en           in   1   run enable; 0 freezes all sequencing
//  pix_tick     out  1   one-clk strobe, once per DIV clks while en=1
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  video_on     out  1   1 while (x,y) is inside the visible area
//  x            out  10  horizontal count, 0..H_TOTAL-1
//  y            out  10  vertical count, 0..V_TOTAL-1
//  line_start   out  1   one-clk pulse when x wraps to 0
//  frame_start  out  1   one-clk pulse when (x,y) wraps to (0,0)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Reset: rst sampled low at posedge clk. Next cycle: div_cnt=0, x=0, y=0, pix_tick=0,
//    line_start=0, frame_start=0, video_on=0, hsync=vsync=~SYNC_POL.
//    Reset mid-frame aborts the scan and restarts at (0,0).
//  - Divider: while en=1, div_cnt counts 0..DIV-1 and wraps.
//    pix_tick is registered and is 1 for exactly the cycle after div_cnt==DIV-1.
//    First pix_tick after reset release arrives DIV cycles after rst goes high.
//  - Scan update: all updates occur in the cycle pix_tick=1.
//    If x<H_TOTAL-1, x increments.
//    Otherwise x wraps to 0; y then increments, or wraps to 0 if it was at V_TOTAL-1.
//  - All outputs are registered and decoded from next-state x/y, so decodes align with x/y (zero skew).
//    hsync = SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
//    vsync = SYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
//    video_on = (x<H_ACTIVE) && (y<V_ACTIVE) && out-of-reset.
//  - line_start: 1 only in the pix_tick cycle where x becomes 0.
//    frame_start: 1 only in the pix_tick cycle where x and y both become 0; implies line_start.
//    Neither pulses at reset; the first frame_start occurs at the first full-frame wrap.
//  - en=0: div_cnt, x, y and all levels hold; pix_tick, line_start and frame_start forced 0.
//    en re-asserted: divider resumes from its held count. No skipped or duplicated pixels.
//  - rst low has priority over en.
//  - Counter width: 10 bits. H_TOTAL and V_TOTAL must each be <=1024; x and y never exceed TOTAL-1.
// TESTING
//  1 Reset: hold rst=0 5 clks, en=1 -> all outputs at reset values; hsync=vsync=1; x=y=0.
//  2 Tick rate: release rst, en=1 -> pix_tick period exactly 4 clks; first tick at clk 4.
//    DIV=1 build -> pix_tick high every clk.
//  3 Line timing: run 1 line -> hsync low for x=656..751 (96 ticks = 384 clks); video_on high x=0..639;
//    line_start spacing 800 ticks = 3200 clks.
//  4 Frame timing: run 2 frames -> vsync low on y=490..491 only; frame_start spacing 420000 ticks = 1680000 clks;
//    x=799,y=524 followed by x=0,y=0 with frame_start=1.
//  5 Freeze: drop en for 37 clks at x=300,y=100 -> x, y, syncs held, no strobes;
//    on re-enable the next tick gives x=301 with no pixel lost.
//  6 Mid-frame reset: pulse rst=0 1 clk at x=700,y=491 (hsync, vsync asserted) -> next clk x=y=0,
//    syncs deasserted; scan restarts cleanly.

Source files
------------

// File: rtl/vga_timing_if.sv
// Scan-side bundle of the VGA timing controller: run enable in, strobes/decodes/coordinates out.
interface vga_timing_if;
    logic       en;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;

    modport master (output en, input pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start);
    modport slave  (input en, output pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing generator: clock-enable pixel strobe, h/v scan counters and
// registered sync/blank decodes that change in the same cycle as x/y.
module vga_timing_ctrl #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.slave   bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          div_wrap;
    logic [9:0]    x, y, nx, ny;
    logic          pix_tick, hsync, vsync, video_on, line_start, frame_start;

    assign div_wrap = (div_cnt == DW'(DIV - 1));

    // Next scan position; decodes below are taken from it so they never lag x/y.
    always_comb begin
        nx = x + 10'd1;
        ny = y;
        if (x == 10'(H_TOTAL - 1)) begin
            nx = 10'd0;
            ny = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt     <= '0;
            x           <= 10'd0;
            y           <= 10'd0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else if (bus.en) begin
            div_cnt     <= div_wrap ? '0 : DW'(div_cnt + 1'b1);
            pix_tick    <= div_wrap;
            line_start  <= div_wrap && (nx == 10'd0);
            frame_start <= div_wrap && (nx == 10'd0) && (ny == 10'd0);
            if (div_wrap) begin
                x        <= nx;
                y        <= ny;
                hsync    <= (nx >= 10'(H_ACTIVE + H_FP) && nx < 10'(H_ACTIVE + H_FP + H_SYNC))
                            ? SYNC_POL : ~SYNC_POL;
                vsync    <= (ny >= 10'(V_ACTIVE + V_FP) && ny < 10'(V_ACTIVE + V_FP + V_SYNC))
                            ? SYNC_POL : ~SYNC_POL;
                video_on <= (nx < 10'(H_ACTIVE)) && (ny < 10'(V_ACTIVE));
            end
        end else begin
            // Frozen: counters and levels hold, strobes drop.
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.pix_tick    = pix_tick;
    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    assign bus.video_on    = video_on;
    assign bus.line_start  = line_start;
    assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunk raster (17x11) so whole frames fit in a short run;
// a second instance covers DIV=1 with active-high syncs.
module tb_vga_timing_ctrl;
    localparam int DIV = 3;
    localparam int HA = 10, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if bus ();
    vga_timing_if bus1 ();
    assign bus1.en = bus.en;

    vga_timing_ctrl #(.DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    vga_timing_ctrl #(.DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k counts enabled clock edges since reset. Pixel index is k/div;
    // a strobe is visible right after an enabled edge that completes a divide period.
    int k = 0;
    bit edge_en = 1'b0;
    bit seen = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            k <= 0; edge_en <= 1'b0; seen <= 1'b1;
        end else if (bus.en) begin
            k <= k + 1; edge_en <= 1'b1;
        end else begin
            edge_en <= 1'b0;
        end
    end

    task automatic check_inst(input string tag, input int div, input bit pol,
                              input logic [9:0] ax, input logic [9:0] ay,
                              input logic apt, input logic ahs, input logic avs,
                              input logic avo, input logic als, input logic afs);
        int p, ex, ey;
        bit tick, started, ehs, evs;
        p       = k / div;
        ex      = p % HT;
        ey      = (p / HT) % VT;
        tick    = edge_en && (k > 0) && (k % div == 0);
        started = (k >= div);
        ehs     = (started && ex >= HA + HF && ex < HA + HF + HS) ? pol : ~pol;
        evs     = (started && ey >= VA + VF && ey < VA + VF + VS) ? pol : ~pol;
        cmp({tag, ".x"}, 32'(ax), 32'(ex));
        cmp({tag, ".y"}, 32'(ay), 32'(ey));
        cmp({tag, ".pix_tick"}, 32'(apt), 32'(tick));
        cmp({tag, ".hsync"}, 32'(ahs), 32'(ehs));
        cmp({tag, ".vsync"}, 32'(avs), 32'(evs));
        cmp({tag, ".video_on"}, 32'(avo), 32'(started && ex < HA && ey < VA));
        cmp({tag, ".line_start"}, 32'(als), 32'(tick && ex == 0));
        cmp({tag, ".frame_start"}, 32'(afs), 32'(tick && ex == 0 && ey == 0));
    endtask

    always @(negedge clk) begin
        if (seen) begin
            check_inst("div3", DIV, 1'b0, bus.x, bus.y, bus.pix_tick, bus.hsync, bus.vsync,
                       bus.video_on, bus.line_start, bus.frame_start);
            check_inst("div1", 1, 1'b1, bus1.x, bus1.y, bus1.pix_tick, bus1.hsync, bus1.vsync,
                       bus1.video_on, bus1.line_start, bus1.frame_start);
        end
    end

    // Returns at the negedge of the tick cycle that lands on (tx,ty); bounded.
    task automatic wait_for(input int tx, input int ty);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.pix_tick && bus.x == 10'(tx) && bus.y == 10'(ty)) && n < 3 * HT * VT * DIV);
        total++;
        if (n >= 3 * HT * VT * DIV) begin
            bad++;
            $display("FAIL wait_for(%0d,%0d): timed out, x=%0d y=%0d", tx, ty, bus.x, bus.y);
        end
    endtask

    task automatic next_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pix_tick && n < 2 * DIV + 50);
    endtask

    initial begin
        int n;
        bus.en = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        cmp("reset.x", 32'(bus.x), 0);
        cmp("reset.y", 32'(bus.y), 0);
        cmp("reset.hsync", 32'(bus.hsync), 1);
        cmp("reset.vsync", 32'(bus.vsync), 1);
        cmp("reset.pix_tick", 32'(bus.pix_tick), 0);
        cmp("reset.video_on", 32'(bus.video_on), 0);
        cmp("reset.frame_start", 32'(bus.frame_start), 0);
        cmp("reset.div1_hsync", 32'(bus1.hsync), 0);

        // Release: first strobe DIV clocks later and it advances x to 1.
        rst = 1'b1;
        repeat (DIV - 1) @(negedge clk);
        cmp("first_tick.early", 32'(bus.pix_tick), 0);
        @(negedge clk);
        cmp("first_tick.pix_tick", 32'(bus.pix_tick), 1);
        cmp("first_tick.x", 32'(bus.x), 1);
        cmp("first_tick.div1_x", 32'(bus1.x), 32'(DIV));

        // Freeze at (5,3) for 37 clocks.
        wait_for(5, 3);
        bus.en = 1'b0;
        repeat (37) begin
            @(negedge clk);
            cmp("freeze.x", 32'(bus.x), 5);
            cmp("freeze.pix_tick", 32'(bus.pix_tick), 0);
        end
        bus.en = 1'b1;
        next_tick(n);
        cmp("resume.latency", 32'(n), 32'(DIV));
        cmp("resume.x", 32'(bus.x), 6);
        cmp("resume.y", 32'(bus.y), 3);

        // Mid-frame reset while both syncs are asserted.
        wait_for(13, 8);
        cmp("midrst.hsync_pre", 32'(bus.hsync), 0);
        cmp("midrst.vsync_pre", 32'(bus.vsync), 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmp("midrst.x", 32'(bus.x), 0);
        cmp("midrst.y", 32'(bus.y), 0);
        cmp("midrst.hsync", 32'(bus.hsync), 1);
        cmp("midrst.vsync", 32'(bus.vsync), 1);

        // Full-frame wrap.
        wait_for(HT - 1, VT - 1);
        next_tick(n);
        cmp("wrap.x", 32'(bus.x), 0);
        cmp("wrap.y", 32'(bus.y), 0);
        cmp("wrap.frame_start", 32'(bus.frame_start), 1);
        cmp("wrap.line_start", 32'(bus.line_start), 1);

        // Random enable gaps and rare resets, checked by the model every cycle.
        repeat (4000) begin
            @(negedge clk);
            bus.en = ($urandom_range(0, 7) != 0);
            rst    = ($urandom_range(0, 999) != 0);
        end
        bus.en = 1'b1;
        rst = 1'b1;
        repeat (2 * HT * VT * DIV) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
